// File: rtl/cobertura_pkg.sv
// Shared types and constants for the motorised roof controller.
package cobertura_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ABRINDO  = 2'd1,
    FECHANDO = 2'd2,
    ERRO     = 2'd3
  } painel_state_t;

  localparam logic [1:0] MODO_AUTO   = 2'd0;
  localparam logic [1:0] MODO_ABRE   = 2'd1;
  localparam logic [1:0] MODO_FECHA  = 2'd2;
  localparam logic [1:0] MODO_SEGURA = 2'd3;

endpackage

// File: rtl/cobertura_if.sv
// Sensor, limit-switch and motor-command bundle between the field side and the controller.
interface cobertura_if #(
  parameter int N_PAINEIS = 2
);
  logic                 luz;
  logic                 umidade;
  logic [1:0]           modo;
  logic [N_PAINEIS-1:0] fd;
  logic [N_PAINEIS-1:0] fe;
  logic                 clr_erro;
  logic [N_PAINEIS-1:0] abrir;
  logic [N_PAINEIS-1:0] fechar;
  logic [N_PAINEIS-1:0] erro;

  modport master (
    output luz, umidade, modo, fd, fe, clr_erro,
    input  abrir, fechar, erro
  );

  modport slave (
    input  luz, umidade, modo, fd, fe, clr_erro,
    output abrir, fechar, erro
  );
endinterface

// File: rtl/cobertura_painel.sv
// One roof panel: motion FSM with a run timer that turns a stalled motion into a fault.
module cobertura_painel
  import cobertura_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic quer_abrir_i,
  input  logic quer_fechar_i,
  input  logic fd_i,
  input  logic fe_i,
  input  logic clr_erro_i,
  output logic abrir_o,
  output logic fechar_o,
  output logic erro_o
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  painel_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          abrir_q, fechar_q, erro_q;
  logic          falha_s;

  assign falha_s = fd_i & fe_i;

  // Next-state logic; checks are ordered fault > limit > command withdrawn > timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PARADO: begin
        if (falha_s)                     state_d = ERRO;
        else if (quer_fechar_i && !fe_i) state_d = FECHANDO;
        else if (quer_abrir_i && !fd_i)  state_d = ABRINDO;
        else                             state_d = PARADO;
      end
      ABRINDO: begin
        if (falha_s)                  state_d = ERRO;
        else if (fd_i)                state_d = PARADO;
        else if (!quer_abrir_i)       state_d = PARADO;
        else if (timer_q == TIMER_MAX) state_d = ERRO;
        else                          state_d = ABRINDO;
      end
      FECHANDO: begin
        if (falha_s)                  state_d = ERRO;
        else if (fe_i)                state_d = PARADO;
        else if (!quer_fechar_i)      state_d = PARADO;
        else if (timer_q == TIMER_MAX) state_d = ERRO;
        else                          state_d = FECHANDO;
      end
      ERRO: begin
        if (clr_erro_i && !falha_s) state_d = PARADO;
        else                        state_d = ERRO;
      end
      default: state_d = PARADO;
    endcase
  end

  // Motions always start from PARADO, so a state change into a motion state is an entry.
  always_comb begin
    timer_d = '0;
    if ((state_d == ABRINDO || state_d == FECHANDO) && state_d == state_q) begin
      timer_d = timer_q + TW'(1'b1);
    end else begin
      timer_d = '0;
    end
  end

  // State, timer and output registers; outputs decode the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PARADO;
      timer_q  <= '0;
      abrir_q  <= 1'b0;
      fechar_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      abrir_q  <= (state_d == ABRINDO);
      fechar_q <= (state_d == FECHANDO);
      erro_q   <= (state_d == ERRO);
    end
  end

  assign abrir_o  = abrir_q;
  assign fechar_o = fechar_q;
  assign erro_o   = erro_q;

endmodule

// File: rtl/cobertura_ctrl.sv
// Roof controller top: debounces light/rain sensors, decodes the operator mode and drives N panels.
module cobertura_ctrl
  import cobertura_pkg::*;
#(
  parameter int N_PAINEIS = 2,
  parameter int DEBOUNCE  = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  cobertura_if.slave  bus
);
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] CNT_MAX = DW'(DEBOUNCE - 1);

  logic          luz_f_q, luz_f_d, umidade_f_q, umidade_f_d;
  logic [DW-1:0] luz_cnt_q, luz_cnt_d, umidade_cnt_q, umidade_cnt_d;
  logic          quer_abrir, quer_fechar;
  logic [N_PAINEIS-1:0] abrir_s, fechar_s, erro_s;

  // Returns {next filtered value, next counter}; any sample equal to the filtered value restarts the count.
  function automatic logic [DW:0] debounce_step(input logic raw, input logic filt,
                                                input logic [DW-1:0] cnt);
    if (raw == filt) begin
      return {filt, {DW{1'b0}}};
    end else if (cnt == CNT_MAX) begin
      return {raw, {DW{1'b0}}};
    end else begin
      return {filt, cnt + DW'(1'b1)};
    end
  endfunction

  // Debounce next-state for both sensors.
  always_comb begin
    {luz_f_d, luz_cnt_d}         = debounce_step(bus.luz, luz_f_q, luz_cnt_q);
    {umidade_f_d, umidade_cnt_d} = debounce_step(bus.umidade, umidade_f_q, umidade_cnt_q);
  end

  // Filtered sensors come out of reset as bright and wet so the roof closes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      luz_f_q       <= 1'b1;
      umidade_f_q   <= 1'b1;
      luz_cnt_q     <= '0;
      umidade_cnt_q <= '0;
    end else begin
      luz_f_q       <= luz_f_d;
      umidade_f_q   <= umidade_f_d;
      luz_cnt_q     <= luz_cnt_d;
      umidade_cnt_q <= umidade_cnt_d;
    end
  end

  // Command decode shared by every panel; rain alone forces closing in auto.
  always_comb begin
    quer_abrir  = 1'b0;
    quer_fechar = 1'b0;
    case (bus.modo)
      MODO_AUTO: begin
        quer_abrir  = ~luz_f_q & ~umidade_f_q;
        quer_fechar = luz_f_q | umidade_f_q;
      end
      MODO_ABRE:   quer_abrir  = 1'b1;
      MODO_FECHA:  quer_fechar = 1'b1;
      MODO_SEGURA: begin
        quer_abrir  = 1'b0;
        quer_fechar = 1'b0;
      end
      default: begin
        quer_abrir  = 1'b0;
        quer_fechar = 1'b0;
      end
    endcase
  end

  for (genvar i = 0; i < N_PAINEIS; i++) begin : g_painel
    cobertura_painel #(.TIMEOUT(TIMEOUT)) u_painel (
      .clk           (clk),
      .rst           (rst),
      .quer_abrir_i  (quer_abrir),
      .quer_fechar_i (quer_fechar),
      .fd_i          (bus.fd[i]),
      .fe_i          (bus.fe[i]),
      .clr_erro_i    (bus.clr_erro),
      .abrir_o       (abrir_s[i]),
      .fechar_o      (fechar_s[i]),
      .erro_o        (erro_s[i])
    );
  end

  assign bus.abrir  = abrir_s;
  assign bus.fechar = fechar_s;
  assign bus.erro   = erro_s;

endmodule
